// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks in-flight register writes from EX to WB, stalls decode on RAW hazards.
// Define ISSUE_FWD_EN for a forwarding back-end (fwd_a_o/fwd_b_o ports, load-use hazards only).
module issue_scoreboard #(
  parameter int DEPTH = 3,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid_i,
  input  logic [4:0]    id_rsa_i,
  input  logic [4:0]    id_rsb_i,
  input  logic          id_rsa_used_i,
  input  logic          id_rsb_used_i,
  input  logic [4:0]    id_rd_i,
  input  logic          id_we_i,
  input  logic          id_memtoreg_i,
  input  logic          ex_ready_i,
  input  logic          flush_i,
  output logic          issue_o,
  output logic          id_stall_o,
  output logic          hazard_a_o,
  output logic          hazard_b_o,
  output logic          wb_we_o,
  output logic [4:0]    wb_rd_o,
  output logic [CW-1:0] inflight_o
`ifdef ISSUE_FWD_EN
  ,
  output logic [CW-1:0] fwd_a_o,
  output logic [CW-1:0] fwd_b_o
`endif
);

  logic [DEPTH-1:0] r_vld, r_we, r_mtr;
  logic [4:0]       r_rd [DEPTH];
  logic             r_wb_we;
  logic [4:0]       r_wb_rd;
  logic [CW-1:0]    r_inflight;

  logic [DEPTH-1:0] w_match_a, w_match_b, w_keep;
  logic [DEPTH-1:0] w_vld_n, w_we_n, w_mtr_n;
  logic [4:0]       w_rd_n [DEPTH];
  logic             w_hit_a, w_hit_b, w_issue, w_commit;
  logic [CW-1:0]    w_cnt_n;
  logic             w_unused_mtr;

  // The oldest memtoreg bit only shifts out; nothing reads it.
  assign w_unused_mtr = r_mtr[DEPTH-1];

  always_comb begin
    w_match_a = '0;
    w_match_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_match_a[k] = r_vld[k] & r_we[k] & (r_rd[k] == id_rsa_i);
      w_match_b[k] = r_vld[k] & r_we[k] & (r_rd[k] == id_rsb_i);
    end
  end

`ifdef ISSUE_FWD_EN
  assign w_hit_a = w_match_a[0] & r_mtr[0];
  assign w_hit_b = w_match_b[0] & r_mtr[0];

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_a_o = '0;
    fwd_b_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_match_a[k]) fwd_a_o = CW'(k + 1);
      if (w_match_b[k]) fwd_b_o = CW'(k + 1);
    end
  end
`else
  assign w_hit_a = |w_match_a;
  assign w_hit_b = |w_match_b;
`endif

  assign hazard_a_o = id_valid_i & id_rsa_used_i & (id_rsa_i != 5'd0) & w_hit_a;
  assign hazard_b_o = id_valid_i & id_rsb_used_i & (id_rsb_i != 5'd0) & w_hit_b;
  assign w_issue    = id_valid_i & ex_ready_i & ~flush_i & ~hazard_a_o & ~hazard_b_o;
  assign issue_o    = w_issue;
  assign id_stall_o = id_valid_i & ~w_issue;

  // Flush masks everything younger than WB before the shift, so flushed entries never commit.
  always_comb begin
    w_keep = r_vld;
    if (flush_i) w_keep[DEPTH-2:0] = '0;
    w_vld_n  = w_keep;
    w_we_n   = r_we;
    w_mtr_n  = r_mtr;
    w_rd_n   = r_rd;
    w_commit = 1'b0;
    if (ex_ready_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        w_vld_n[k] = w_keep[k-1];
        w_we_n[k]  = r_we[k-1];
        w_mtr_n[k] = r_mtr[k-1];
        w_rd_n[k]  = r_rd[k-1];
      end
      w_vld_n[0] = w_issue;
      w_we_n[0]  = w_issue & id_we_i & (id_rd_i != 5'd0);
      w_mtr_n[0] = w_issue & id_memtoreg_i;
      w_rd_n[0]  = id_rd_i;
      w_commit   = w_keep[DEPTH-2] & r_we[DEPTH-2];
    end
    w_cnt_n = '0;
    for (int k = 0; k < DEPTH; k++) w_cnt_n = w_cnt_n + CW'(w_vld_n[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= '0;
      r_we       <= '0;
      r_mtr      <= '0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_inflight <= '0;
    end else begin
      r_vld      <= w_vld_n;
      r_we       <= w_we_n;
      r_mtr      <= w_mtr_n;
      r_wb_we    <= w_commit;
      if (w_commit) r_wb_rd <= r_rd[DEPTH-2];
      r_inflight <= w_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    r_rd <= w_rd_n;
  end

  assign wb_we_o    = r_wb_we;
  assign wb_rd_o    = r_wb_rd;
  assign inflight_o = r_inflight;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (DEPTH=3); forwarding scenario runs when ISSUE_FWD_EN is defined.
module tb_issue_scoreboard;
  localparam int DEPTH = 3;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rsa_used, id_rsb_used, id_we, id_memtoreg;
  logic [4:0]    id_rsa, id_rsb, id_rd;
  logic          ex_ready, flush;
  logic          issue, stall, haz_a, haz_b, wb_we;
  logic [4:0]    wb_rd;
  logic [CW-1:0] inflight;
`ifdef ISSUE_FWD_EN
  logic [CW-1:0] fwd_a, fwd_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] obs;
  assign obs = {issue, stall, haz_a, haz_b, wb_we, wb_rd, inflight};

  issue_scoreboard #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_rsa_i(id_rsa), .id_rsb_i(id_rsb),
    .id_rsa_used_i(id_rsa_used), .id_rsb_used_i(id_rsb_used),
    .id_rd_i(id_rd), .id_we_i(id_we), .id_memtoreg_i(id_memtoreg),
    .ex_ready_i(ex_ready), .flush_i(flush),
    .issue_o(issue), .id_stall_o(stall), .hazard_a_o(haz_a), .hazard_b_o(haz_b),
    .wb_we_o(wb_we), .wb_rd_o(wb_rd), .inflight_o(inflight)
`ifdef ISSUE_FWD_EN
    , .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Expected {issue, stall, haz_a, haz_b, wb_we, wb_rd, inflight}
  function automatic logic [11:0] mk(input logic is, input logic st, input logic ha, input logic hb,
                                     input logic we, input logic [4:0] rd, input logic [1:0] inf);
    return {is, st, ha, hb, we, rd, inf};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic ua, input logic [4:0] b,
                       input logic ub, input logic [4:0] d, input logic we, input logic m);
    id_valid = v; id_rsa = a; id_rsa_used = ua; id_rsb = b; id_rsb_used = ub;
    id_rd = d; id_we = we; id_memtoreg = m;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_ready = 1'b1; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] rds [3];
    logic [11:0] e;
    rds = '{5'd7, 5'd6, 5'd5};
    do_reset();
    e = mk(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL reset_idle: got %h required %h", obs, e); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, rds[i], 1, 0);
      e = mk(1, 0, 0, 0, 0, 0, 2'(i));
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL reset_fill%0d: got %h required %h", i, obs, e); end
      cyc();
    end
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    e = mk(0, 1, 1, 0, 1, 7, 3);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL reset_prefull: got %h required %h", obs, e); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    e = mk(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL reset_midstream: got %h required %h", obs, e); end
    cyc();
  endtask

  task automatic test_raw();
    logic [11:0] e;
    do_reset();
    drive(1, 1, 1, 2, 1, 5, 1, 0);
    e = mk(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL raw_producer: got %h required %h", obs, e); end
    cyc();
    drive(1, 5, 1, 0, 0, 6, 1, 0);
    for (int i = 0; i < 3; i++) begin
      e = mk(0, 1, 1, 0, (i == 2), (i == 2) ? 5'd5 : 5'd0, 1);
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL raw_stall%0d: got %h required %h", i, obs, e); end
      cyc();
    end
    e = mk(1, 0, 0, 0, 0, 5, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL raw_release: got %h required %h", obs, e); end
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    e = mk(0, 0, 0, 0, 0, 5, 1);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL raw_dependent_in: got %h required %h", obs, e); end
  endtask

  task automatic test_x0();
    logic [11:0] e;
    int inf_e [4];
    inf_e = '{2, 2, 1, 0};
    do_reset();
    drive(1, 0, 1, 0, 0, 0, 1, 0);
    e = mk(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL x0_write: got %h required %h", obs, e); end
    cyc();
    drive(1, 0, 1, 0, 1, 0, 0, 0);
    e = mk(1, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL x0_read: got %h required %h", obs, e); end
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      e = mk(0, 0, 0, 0, 0, 0, 2'(inf_e[i]));
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL x0_drain%0d: got %h required %h", i, obs, e); end
      cyc();
    end
  endtask

  task automatic test_hold();
    logic [11:0] e;
    int commits;
    logic we_e [5];
    int   rd_e [5];
    int   inf_e [5];
    we_e  = '{0, 0, 1, 0, 0};
    rd_e  = '{0, 0, 5, 5, 5};
    inf_e = '{1, 1, 1, 0, 0};
    do_reset();
    drive(1, 1, 1, 0, 0, 5, 1, 0);
    e = mk(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL hold_producer: got %h required %h", obs, e); end
    cyc();
    ex_ready = 1'b0;
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      e = mk(0, 1, 0, 0, 0, 0, 1);
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL hold_frozen%0d: got %h required %h", i, obs, e); end
      cyc();
    end
    ex_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    commits = 0;
    for (int i = 0; i < 5; i++) begin
      e = mk(0, 0, 0, 0, we_e[i], 5'(rd_e[i]), 2'(inf_e[i]));
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL hold_release%0d: got %h required %h", i, obs, e); end
      commits += int'(wb_we);
      cyc();
    end
    n_cmp++; if (commits !== 1) begin n_bad++; $display("FAIL hold_commit_count: got %0d required 1", commits); end
  endtask

  task automatic test_flush();
    logic [11:0] e;
    logic [4:0] rds [3];
    rds = '{5'd3, 5'd4, 5'd7};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, rds[i], 1, 0);
      e = mk(1, 0, 0, 0, 0, 0, 2'(i));
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL flush_fill%0d: got %h required %h", i, obs, e); end
      cyc();
    end
    flush = 1'b1;
    drive(1, 7, 1, 0, 0, 0, 0, 0);
    e = mk(0, 1, 1, 0, 1, 3, 3);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL flush_with_hazard: got %h required %h", obs, e); end
    cyc();
    flush = 1'b0;
    #1;
    e = mk(1, 0, 0, 0, 0, 3, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL flush_after: got %h required %h", obs, e); end
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    e = mk(0, 0, 0, 0, 0, 3, 1);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL flush_reader_in: got %h required %h", obs, e); end

    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, rds[i], 1, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ex_ready = 1'b0;
    flush = 1'b1;
    #1;
    e = mk(0, 0, 0, 0, 1, 3, 3);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL flushhold_before: got %h required %h", obs, e); end
    cyc();
    flush = 1'b0;
    #1;
    e = mk(0, 0, 0, 0, 0, 3, 1);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL flushhold_kept_wb: got %h required %h", obs, e); end
    ex_ready = 1'b1;
    cyc();
    e = mk(0, 0, 0, 0, 0, 3, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL flushhold_retire: got %h required %h", obs, e); end
  endtask

  task automatic test_srcb();
    logic [11:0] e;
    do_reset();
    drive(1, 0, 0, 0, 0, 9, 1, 0);
    e = mk(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL srcb_producer: got %h required %h", obs, e); end
    cyc();
    drive(1, 1, 1, 9, 0, 0, 0, 0);
    e = mk(1, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL srcb_unused: got %h required %h", obs, e); end
    cyc();
    drive(1, 1, 1, 9, 1, 0, 0, 0);
    e = mk(0, 1, 0, 1, 0, 0, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL srcb_hazard: got %h required %h", obs, e); end
    drive(0, 1, 1, 9, 1, 0, 0, 0);
    e = mk(0, 0, 0, 0, 0, 0, 2);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL srcb_novalid: got %h required %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 5'(10 + i), 1, 0);
      e = mk(1, 0, 0, 0, (i == 3), (i == 3) ? 5'd10 : 5'd0, 2'(i));
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL b2b_issue%0d: got %h required %h", i, obs, e); end
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    e = mk(0, 0, 0, 0, 1, 11, 3);
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL b2b_saturate: got %h required %h", obs, e); end
  endtask

`ifdef ISSUE_FWD_EN
  task automatic test_fwd();
    logic [15:0] e;
    do_reset();
    drive(1, 1, 1, 2, 1, 5, 1, 0);
    e = {mk(1, 0, 0, 0, 0, 0, 0), 2'd0, 2'd0};
    n_cmp++; if ({obs, fwd_a, fwd_b} !== e) begin n_bad++; $display("FAIL fwd_add: got %h required %h", {obs, fwd_a, fwd_b}, e); end
    cyc();
    drive(1, 5, 1, 1, 1, 6, 1, 0);
    e = {mk(1, 0, 0, 0, 0, 0, 1), 2'd1, 2'd0};
    n_cmp++; if ({obs, fwd_a, fwd_b} !== e) begin n_bad++; $display("FAIL fwd_sub: got %h required %h", {obs, fwd_a, fwd_b}, e); end
    cyc();
    drive(1, 2, 1, 0, 0, 8, 1, 1);
    e = {mk(1, 0, 0, 0, 0, 0, 2), 2'd0, 2'd0};
    n_cmp++; if ({obs, fwd_a, fwd_b} !== e) begin n_bad++; $display("FAIL fwd_load: got %h required %h", {obs, fwd_a, fwd_b}, e); end
    cyc();
    drive(1, 8, 1, 8, 1, 9, 1, 0);
    e = {mk(0, 1, 1, 1, 1, 5, 3), 2'd1, 2'd1};
    n_cmp++; if ({obs, fwd_a, fwd_b} !== e) begin n_bad++; $display("FAIL fwd_loaduse: got %h required %h", {obs, fwd_a, fwd_b}, e); end
    cyc();
    e = {mk(1, 0, 0, 0, 1, 6, 2), 2'd2, 2'd2};
    n_cmp++; if ({obs, fwd_a, fwd_b} !== e) begin n_bad++; $display("FAIL fwd_after_stall: got %h required %h", {obs, fwd_a, fwd_b}, e); end
    cyc();
  endtask
`endif

  initial begin
    rst = 1'b1; ex_ready = 1'b1; flush = 1'b0;
    id_valid = 1'b0; id_rsa = '0; id_rsb = '0; id_rsa_used = 1'b0; id_rsb_used = 1'b0;
    id_rd = '0; id_we = 1'b0; id_memtoreg = 1'b0;
    cyc();
`ifdef ISSUE_FWD_EN
    test_x0();
    test_hold();
    test_back_to_back();
    test_fwd();
`else
    test_reset();
    test_raw();
    test_x0();
    test_hold();
    test_flush();
    test_srcb();
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
